// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation runs through one EXEC cycle and is then held in RESP until the consumer takes it.
module alu_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_operand_A,
  output logic [DATA_W-1:0] alu_operand_B,
  output logic [SEL_W-1:0]  alu_Sel,
  input  logic [DATA_W-1:0] alu_Out,
  input  logic [FLAG_W-1:0] alu_Flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic [FLAG_W-1:0] rsp_flag,
  output logic              rsp_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       grant_id;
  logic       in_idle;
  logic       accept;

  // On a tie, the requester that did not win last time is granted.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign in_idle    = (state == IDLE) && !rst;
  assign req0_ready = in_idle && req0_valid && (grant_id == 1'b0);
  assign req1_ready = in_idle && req1_valid && (grant_id == 1'b1);
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      alu_operand_A <= '0;
      alu_operand_B <= '0;
      alu_Sel       <= '0;
      rsp_valid     <= 1'b0;
      rsp_out       <= '0;
      rsp_flag      <= '0;
      rsp_id        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_operand_A <= grant_id ? req1_a   : req0_a;
            alu_operand_B <= grant_id ? req1_b   : req0_b;
            alu_Sel       <= grant_id ? req1_sel : req0_sel;
            rsp_id        <= grant_id;
            last_grant    <= grant_id;
            state         <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_Out;
          rsp_flag  <= alu_Flag;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with a small combinational ALU model.
module tb_alu_rr_scheduler;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int FLAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SEL_W-1:0]  req0_sel, req1_sel;
  logic [DATA_W-1:0] alu_operand_A, alu_operand_B, alu_Out;
  logic [SEL_W-1:0]  alu_Sel;
  logic [FLAG_W-1:0] alu_Flag;
  logic rsp_valid, rsp_ready, rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic [FLAG_W-1:0] rsp_flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_id[$];
  int hs_cyc[$];
  int rs_id[$];
  int rs_out[$];
  int rs_flag[$];

  always #5 clk = ~clk;

  // Bench ALU: out = A - B + (Sel >> 1), flag = {A[7], Sel[3], Sel[2], B[0]}
  assign alu_Out  = alu_operand_A - alu_operand_B + {4'h0, alu_Sel >> 1};
  assign alu_Flag = {alu_operand_A[7], alu_Sel[3], alu_Sel[2], alu_operand_B[0]};

  alu_rr_scheduler #(.DATA_W(DATA_W), .SEL_W(SEL_W), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_Sel(alu_Sel),
    .alu_Out(alu_Out), .alu_Flag(alu_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag), .rsp_id(rsp_id)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log handshakes and completed responses late in each low phase, after inputs settle.
  always @(negedge clk) begin
    #2;
    if (req0_valid && req0_ready) begin hs_id.push_back(0); hs_cyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin hs_id.push_back(1); hs_cyc.push_back(cyc); end
    if (rsp_valid && rsp_ready) begin
      rs_id.push_back(int'(rsp_id));
      rs_out.push_back(int'(rsp_out));
      rs_flag.push_back(int'(rsp_flag));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] sel);
    if (idx == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  task automatic clearLogs();
    hs_id.delete(); hs_cyc.delete(); rs_id.delete(); rs_out.delete(); rs_flag.delete();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitRspValid(input int budget);
    int k;
    k = 0;
    while (!rsp_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) checkOutput("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 8'h11, 8'h22, 4'h3);
    applyStimulus(1, 1'b1, 8'h44, 8'h55, 4'h6);

    // Reset: readys low while rst high, then zeroed outputs
    @(negedge clk); #1;
    checkOutput("rst_req0_ready", 32'(req0_ready), 0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'h0);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_out", 32'(rsp_out), 0);
    checkOutput("rst_rsp_flag", 32'(rsp_flag), 0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 0);
    checkOutput("rst_alu_A", 32'(alu_operand_A), 0);
    checkOutput("rst_alu_B", 32'(alu_operand_B), 0);
    checkOutput("rst_alu_Sel", 32'(alu_Sel), 0);

    // Single op from req0 with latency check
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'hFF, 8'hFF, 4'h2);
    #1;
    checkOutput("single_req0_ready", 32'(req0_ready), 1);
    checkOutput("single_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'h0);
    #1;
    checkOutput("single_exec_A", 32'(alu_operand_A), 32'hFF);
    checkOutput("single_exec_B", 32'(alu_operand_B), 32'hFF);
    checkOutput("single_exec_Sel", 32'(alu_Sel), 32'h2);
    checkOutput("single_exec_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checkOutput("single_rsp_valid", 32'(rsp_valid), 1);
    checkOutput("single_rsp_out", 32'(rsp_out), 32'h01);
    checkOutput("single_rsp_flag", 32'(rsp_flag), 32'h9);
    checkOutput("single_rsp_id", 32'(rsp_id), 0);
    @(negedge clk); #1;
    checkOutput("single_done_rsp_valid", 32'(rsp_valid), 0);

    // Tie after reset: grants alternate 0,1,0,1 every 3 cycles
    applyReset();
    clearLogs();
    rsp_ready = 1'b1;
    applyStimulus(0, 1'b1, 8'h10, 8'h03, 4'h4);
    applyStimulus(1, 1'b1, 8'h20, 8'h05, 4'h8);
    waitCycles(10);
    applyStimulus(0, 1'b0, 8'h10, 8'h03, 4'h4);
    applyStimulus(1, 1'b0, 8'h20, 8'h05, 4'h8);
    waitCycles(4);
    checkOutput("tie_hs_count", 32'(hs_id.size()), 4);
    checkOutput("tie_rsp_count", 32'(rs_id.size()), 4);
    if (hs_id.size() == 4 && rs_id.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("tie_grant%0d", i), 32'(hs_id[i]), 32'(i % 2));
        checkOutput($sformatf("tie_rsp_id%0d", i), 32'(rs_id[i]), 32'(i % 2));
        checkOutput($sformatf("tie_rsp_out%0d", i), 32'(rs_out[i]), (i % 2) ? 32'h1F : 32'h0F);
        checkOutput($sformatf("tie_rsp_flag%0d", i), 32'(rs_flag[i]), (i % 2) ? 32'h5 : 32'h3);
        if (i > 0) checkOutput($sformatf("tie_spacing%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 3);
      end
    end

    // Backpressure: response held for 5 cycles while req1 waits
    @(negedge clk);
    clearLogs();
    rsp_ready = 1'b0;
    applyStimulus(0, 1'b1, 8'h33, 8'h11, 4'h0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'h0);
    applyStimulus(1, 1'b1, 8'h40, 8'h01, 4'h1);
    waitRspValid(10);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_rsp_valid%0d", i), 32'(rsp_valid), 1);
      checkOutput($sformatf("bp_rsp_out%0d", i), 32'(rsp_out), 32'h22);
      checkOutput($sformatf("bp_rsp_flag%0d", i), 32'(rsp_flag), 32'h1);
      checkOutput($sformatf("bp_rsp_id%0d", i), 32'(rsp_id), 0);
      checkOutput($sformatf("bp_req0_ready%0d", i), 32'(req0_ready), 0);
      checkOutput($sformatf("bp_req1_ready%0d", i), 32'(req1_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("bp_waiting_req1_ready", 32'(req1_ready), 1);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    #1;
    checkOutput("bp_req1_exec_A", 32'(alu_operand_A), 32'h40);
    waitCycles(3);

    // Single requester: req1 alone gets three grants in a row
    clearLogs();
    applyStimulus(1, 1'b1, 8'h80, 8'h01, 4'hC);
    waitCycles(7);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    waitCycles(4);
    checkOutput("solo_hs_count", 32'(hs_id.size()), 3);
    checkOutput("solo_rsp_count", 32'(rs_id.size()), 3);
    if (hs_id.size() == 3 && rs_id.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("solo_grant%0d", i), 32'(hs_id[i]), 1);
        checkOutput($sformatf("solo_rsp_id%0d", i), 32'(rs_id[i]), 1);
        checkOutput($sformatf("solo_rsp_out%0d", i), 32'(rs_out[i]), 32'h85);
        checkOutput($sformatf("solo_rsp_flag%0d", i), 32'(rs_flag[i]), 32'hF);
      end
    end

    // Reset during EXEC discards the op; next tie goes to req0
    clearLogs();
    applyStimulus(1, 1'b1, 8'h77, 8'h02, 4'h4);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    #1;
    checkOutput("midrst_exec_A", 32'(alu_operand_A), 32'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("midrst_rsp_out", 32'(rsp_out), 0);
    checkOutput("midrst_rsp_flag", 32'(rsp_flag), 0);
    checkOutput("midrst_rsp_id", 32'(rsp_id), 0);
    checkOutput("midrst_alu_A", 32'(alu_operand_A), 0);
    checkOutput("midrst_alu_Sel", 32'(alu_Sel), 0);
    waitCycles(4);
    checkOutput("midrst_no_rsp", 32'(rs_id.size()), 0);
    applyStimulus(0, 1'b1, 8'h09, 8'h01, 4'h0);
    applyStimulus(1, 1'b1, 8'h06, 8'h01, 4'h0);
    #1;
    checkOutput("midrst_tie_req0_ready", 32'(req0_ready), 1);
    checkOutput("midrst_tie_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'h0);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    waitCycles(3);

    // Late valid: req0 arrives during RESP of a req1 op
    clearLogs();
    applyStimulus(1, 1'b1, 8'h02, 8'h01, 4'h0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 8'h5A, 8'h0A, 4'h2);
    #1;
    checkOutput("late_resp_valid", 32'(rsp_valid), 1);
    checkOutput("late_resp_id", 32'(rsp_id), 1);
    checkOutput("late_resp_out", 32'(rsp_out), 32'h01);
    checkOutput("late_resp_req0_ready", 32'(req0_ready), 0);
    @(negedge clk); #1;
    checkOutput("late_idle_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("late_idle_req0_ready", 32'(req0_ready), 1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'h0);
    #1;
    checkOutput("late_exec_A", 32'(alu_operand_A), 32'h5A);
    checkOutput("late_exec_B", 32'(alu_operand_B), 32'h0A);
    checkOutput("late_exec_Sel", 32'(alu_Sel), 32'h2);
    @(negedge clk); #1;
    checkOutput("late_rsp_out", 32'(rsp_out), 32'h51);
    checkOutput("late_rsp_id", 32'(rsp_id), 0);
    waitCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
